// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI voice allocator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package midi_pkg;

  localparam int MIDI_PITCH_W = 8;
  localparam int MIDI_VEL_W   = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    APPLY  = 2'd2
  } state_t;

  // Decision made in LOOKUP and carried into APPLY.
  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RANGE = 2'd1,
    ACT_ON    = 2'd2,
    ACT_OFF   = 2'd3
  } act_t;

  typedef struct packed {
    logic                  note_on;
    logic [MIDI_PITCH_W-1:0] pitch;
    logic [MIDI_VEL_W-1:0]   velocity;
  } note_ev_t;

  // Offset code shown by a voice that is not sounding.
  function automatic int idle_code(input int num_keys);
    return num_keys;
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Least-recently-allocated age bookkeeping; ages stay a permutation of 0..NUM_VOICES-1.
// Latency: ages update on the edge where i_alloc is high; o_oldest_idx follows from registers.
// Backpressure: none, i_alloc is a single-cycle strobe.
// Ports: clk, rst_n, i_alloc (strobe), i_alloc_idx (voice taken), o_oldest_idx (age NUM_VOICES-1).
module voice_age_tracker #(
  parameter int NUM_VOICES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_alloc,
  input  logic [$clog2(NUM_VOICES)-1:0] i_alloc_idx,
  output logic [$clog2(NUM_VOICES)-1:0] o_oldest_idx
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [IDX_W-1:0] r_age [NUM_VOICES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) r_age[i] <= IDX_W'(i);
    end else if (i_alloc) begin
      // Chosen voice becomes youngest; only voices younger than it age by one,
      // so the permutation property is preserved.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (IDX_W'(i) == i_alloc_idx)
          r_age[i] <= '0;
        else if (r_age[i] < r_age[i_alloc_idx])
          r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  always_comb begin
    o_oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (r_age[i] == IDX_W'(NUM_VOICES - 1)) o_oldest_idx = IDX_W'(i);
  end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic note-on/off allocator mapping MIDI pitch to per-voice key offsets with LRA stealing.
// Latency: 2 cycles from acceptance to voice/pulse outputs; one event per 3 cycles.
// Backpressure: EvReady is high only in IDLE; events are held off during LOOKUP and APPLY.
// Ports: clk, rst_n, Ev* handshake/fields, AllOff; VoiceGate/Offset/Velocity, StealPulse, RangePulse.
module midi_voice_allocator
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int BASE_NOTE  = 48,
  parameter int NUM_KEYS   = 24,
  parameter int OFFSET_W   = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           EvValid,
  output logic                           EvReady,
  input  logic                           EvNoteOn,
  input  logic [MIDI_PITCH_W-1:0]        EvPitch,
  input  logic [MIDI_VEL_W-1:0]          EvVelocity,
  input  logic                           AllOff,
  output logic [NUM_VOICES-1:0]          VoiceGate,
  output logic [NUM_VOICES*OFFSET_W-1:0] VoiceOffset,
  output logic [NUM_VOICES*7-1:0]        VoiceVelocity,
  output logic                           StealPulse,
  output logic                           RangePulse
);

  localparam int                  IDX_W    = $clog2(NUM_VOICES);
  localparam logic [OFFSET_W-1:0] IDLE_OFF = OFFSET_W'(idle_code(NUM_KEYS));

  state_t                r_state;
  logic                  r_ready;
  note_ev_t              r_ev;
  act_t                  r_act;
  logic [IDX_W-1:0]      r_idx;
  logic [OFFSET_W-1:0]   r_off;
  logic                  r_new;     // fresh allocation (not a retrigger)
  logic [NUM_VOICES-1:0] r_gate;
  logic [OFFSET_W-1:0]   r_voff [NUM_VOICES];
  logic [MIDI_VEL_W-1:0] r_vvel [NUM_VOICES];
  logic                  r_steal;
  logic                  r_range;

  logic [6:0]          w_pitch7;
  logic [7:0]          w_diff8;
  logic [OFFSET_W-1:0] w_off;
  logic                w_in_range;
  logic                w_is_on;
  logic                w_match, w_free;
  logic [IDX_W-1:0]    w_match_idx, w_free_idx, w_oldest_idx;
  act_t                w_act;
  logic [IDX_W-1:0]    w_idx;
  logic                w_new;
  logic                w_alloc;
  logic                w_unused_pitch_msb;

  assign w_pitch7           = r_ev.pitch[6:0];
  assign w_unused_pitch_msb = r_ev.pitch[7];
  assign w_diff8            = {1'b0, w_pitch7} - 8'(BASE_NOTE);
  assign w_off              = w_diff8[OFFSET_W-1:0];
  assign w_in_range         = ({1'b0, w_pitch7} >= 8'(BASE_NOTE)) &&
                              ({1'b0, w_pitch7} <  8'(BASE_NOTE + NUM_KEYS));
  assign w_is_on            = r_ev.note_on && (r_ev.velocity != '0);

  // Lowest-index gated voice holding the offset, and lowest-index free voice.
  always_comb begin
    w_match     = 1'b0;
    w_match_idx = '0;
    w_free      = 1'b0;
    w_free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (r_gate[i] && (r_voff[i] == w_off)) begin
        w_match     = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_gate[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_act = ACT_NONE;
    w_idx = '0;
    w_new = 1'b0;
    if (!w_in_range) begin
      w_act = ACT_RANGE;
    end else if (w_is_on) begin
      w_act = ACT_ON;
      w_new = !w_match;
      w_idx = w_match ? w_match_idx : (w_free ? w_free_idx : w_oldest_idx);
    end else if (w_match) begin
      w_act = ACT_OFF;
      w_idx = w_match_idx;
    end
  end

  assign w_alloc = (r_state == APPLY) && !AllOff && (r_act == ACT_ON) && r_new;

  voice_age_tracker #(.NUM_VOICES(NUM_VOICES)) u_age (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_alloc      (w_alloc),
    .i_alloc_idx  (r_idx),
    .o_oldest_idx (w_oldest_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_ev    <= '0;
      r_act   <= ACT_NONE;
      r_idx   <= '0;
      r_off   <= '0;
      r_new   <= 1'b0;
      r_gate  <= '0;
      r_steal <= 1'b0;
      r_range <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_voff[i] <= IDLE_OFF;
        r_vvel[i] <= '0;
      end
    end else begin
      r_steal <= 1'b0;
      r_range <= 1'b0;
      case (r_state)
        IDLE: begin
          if (EvValid && r_ready) begin
            r_ev    <= '{note_on: EvNoteOn, pitch: EvPitch, velocity: EvVelocity};
            r_ready <= 1'b0;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_act   <= w_act;
          r_idx   <= w_idx;
          r_off   <= w_off;
          r_new   <= w_new;
          r_state <= APPLY;
        end
        APPLY: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
          if (!AllOff) begin
            case (r_act)
              ACT_ON: begin
                r_gate[r_idx] <= 1'b1;
                r_voff[r_idx] <= r_off;
                r_vvel[r_idx] <= r_ev.velocity;
                // Gate sampled now, so a voice freed by AllOff during LOOKUP is not a steal.
                r_steal       <= r_new && r_gate[r_idx];
              end
              ACT_OFF: begin
                if (r_gate[r_idx] && (r_voff[r_idx] == r_off)) begin
                  r_gate[r_idx] <= 1'b0;
                  r_voff[r_idx] <= IDLE_OFF;
                end
              end
              ACT_RANGE: r_range <= 1'b1;
              default: ;
            endcase
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
      // Placed last so it overrides any APPLY update in the same cycle.
      if (AllOff) begin
        r_gate <= '0;
        for (int i = 0; i < NUM_VOICES; i++) r_voff[i] <= IDLE_OFF;
      end
    end
  end

  assign EvReady    = r_ready;
  assign VoiceGate  = r_gate;
  assign StealPulse = r_steal;
  assign RangePulse = r_range;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
    assign VoiceOffset[g*OFFSET_W +: OFFSET_W] = r_voff[g];
    assign VoiceVelocity[g*7 +: 7]             = r_vvel[g];
  end

endmodule

// File: tb/tb_midi_voice_allocator.sv
module tb_midi_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        EvValid = 1'b0;
  logic        EvReady;
  logic        EvNoteOn = 1'b0;
  logic [7:0]  EvPitch = '0;
  logic [6:0]  EvVelocity = '0;
  logic        AllOff = 1'b0;
  logic [3:0]  VoiceGate;
  logic [19:0] VoiceOffset;
  logic [27:0] VoiceVelocity;
  logic        StealPulse;
  logic        RangePulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  midi_voice_allocator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .EvValid       (EvValid),
    .EvReady       (EvReady),
    .EvNoteOn      (EvNoteOn),
    .EvPitch       (EvPitch),
    .EvVelocity    (EvVelocity),
    .AllOff        (AllOff),
    .VoiceGate     (VoiceGate),
    .VoiceOffset   (VoiceOffset),
    .VoiceVelocity (VoiceVelocity),
    .StealPulse    (StealPulse),
    .RangePulse    (RangePulse)
  );

  function automatic logic [4:0] voff(input int i);
    return VoiceOffset[i*5 +: 5];
  endfunction

  function automatic logic [6:0] vvel(input int i);
    return VoiceVelocity[i*7 +: 7];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the negedge after the result edge.
  task automatic do_ev(input logic on, input logic [7:0] p, input logic [6:0] v);
    int n;
    n = 0;
    while (EvReady !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", EvReady, 1);
    EvValid = 1'b1; EvNoteOn = on; EvPitch = p; EvVelocity = v;
    @(negedge clk);
    EvValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gate"}, VoiceGate, 0);
    chk({tag, "_offsets"}, VoiceOffset, {5'd24, 5'd24, 5'd24, 5'd24});
  endtask

  initial begin
    int exp_rdy [10];
    int exp_gate [10];
    int ev_sent;
    logic [7:0] pitches [3];

    // Reset state
    @(negedge clk);
    chk("rst_ready", EvReady, 1);
    chk_idle("rst");
    chk("rst_vel", VoiceVelocity, 0);
    chk("rst_steal", StealPulse, 0);
    chk("rst_range", RangePulse, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic mapping and range check
    do_ev(1, 8'd48, 7'd100);
    chk("t1_gate_a", VoiceGate, 4'b0001);
    chk("t1_off0", voff(0), 0);
    chk("t1_vel0", vvel(0), 100);
    do_ev(1, 8'd71, 7'd100);
    chk("t1_gate_b", VoiceGate, 4'b0011);
    chk("t1_off1", voff(1), 23);
    do_ev(1, 8'd72, 7'd100);
    chk("t1_range_pulse", RangePulse, 1);
    chk("t1_range_gate", VoiceGate, 4'b0011);
    chk("t1_range_offs", VoiceOffset, {5'd24, 5'd24, 5'd23, 5'd0});
    @(negedge clk);
    chk("t1_range_pulse_end", RangePulse, 0);
    // Pitch bit 7 ignored: 0xB0 is treated as 48
    do_ev(0, 8'hB0, 7'd0);
    chk("t1_msb_off_gate", VoiceGate, 4'b0010);
    chk("t1_msb_off_off0", voff(0), 24);

    // Voice stealing
    do_reset();
    do_ev(1, 8'd50, 7'd100);
    do_ev(1, 8'd52, 7'd100);
    do_ev(1, 8'd54, 7'd100);
    do_ev(1, 8'd56, 7'd100);
    chk("t2_full_gate", VoiceGate, 4'b1111);
    chk("t2_no_steal_yet", StealPulse, 0);
    chk("t2_full_offs", VoiceOffset, {5'd8, 5'd6, 5'd4, 5'd2});
    do_ev(1, 8'd58, 7'd100);
    chk("t2_steal1_pulse", StealPulse, 1);
    chk("t2_steal1_offs", VoiceOffset, {5'd8, 5'd6, 5'd4, 5'd10});
    @(negedge clk);
    chk("t2_steal1_pulse_end", StealPulse, 0);
    do_ev(1, 8'd60, 7'd100);
    chk("t2_steal2_pulse", StealPulse, 1);
    chk("t2_steal2_offs", VoiceOffset, {5'd8, 5'd6, 5'd12, 5'd10});

    // Retrigger
    do_reset();
    do_ev(1, 8'd60, 7'd90);
    chk("t3_off0", voff(0), 12);
    chk("t3_vel0_a", vvel(0), 90);
    do_ev(1, 8'd60, 7'd20);
    chk("t3_retrig_gate", VoiceGate, 4'b0001);
    chk("t3_retrig_vel", vvel(0), 20);
    chk("t3_retrig_steal", StealPulse, 0);

    // Velocity-0 note-on as note-off; unmatched note-off
    do_ev(1, 8'd55, 7'd100);
    chk("t4_gate_on", VoiceGate, 4'b0011);
    chk("t4_off1_on", voff(1), 7);
    do_ev(1, 8'd55, 7'd0);
    chk("t4_vel0_gate", VoiceGate, 4'b0001);
    chk("t4_vel0_off1", voff(1), 24);
    do_ev(0, 8'd57, 7'd64);
    chk("t4_nomatch_gate", VoiceGate, 4'b0001);
    chk("t4_nomatch_offs", VoiceOffset, {5'd24, 5'd24, 5'd24, 5'd12});
    chk("t4_nomatch_pulses", {StealPulse, RangePulse}, 0);
    do_ev(0, 8'd60, 7'd0);
    chk("t4_off60_gate", VoiceGate, 4'b0000);

    // Back-to-back with EvValid held high
    do_reset();
    exp_rdy  = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    exp_gate = '{0, 0, 0, 1, 1, 1, 3, 3, 3, 7};
    pitches  = '{8'd48, 8'd49, 8'd50};
    ev_sent  = 0;
    EvNoteOn = 1'b1; EvVelocity = 7'd64;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t5_ready_k%0d", k), EvReady, exp_rdy[k]);
      chk($sformatf("t5_gate_k%0d", k), VoiceGate, exp_gate[k]);
      if (EvReady === 1'b1 && ev_sent < 3) begin
        EvPitch = pitches[ev_sent];
        EvValid = 1'b1;
        ev_sent++;
      end else if (ev_sent == 3 && EvReady !== 1'b1) begin
        EvValid = 1'b0;
      end
      @(negedge clk);
    end
    EvValid = 1'b0;
    chk("t5_offs", VoiceOffset, {5'd24, 5'd2, 5'd1, 5'd0});

    // AllOff in the APPLY cycle of a note-on
    do_reset();
    do_ev(1, 8'd48, 7'd100);
    chk("t6_pre_gate", VoiceGate, 4'b0001);
    EvValid = 1'b1; EvNoteOn = 1'b1; EvPitch = 8'd50; EvVelocity = 7'd100;
    @(negedge clk);
    EvValid = 1'b0;
    @(negedge clk);
    AllOff = 1'b1;
    @(negedge clk);
    AllOff = 1'b0;
    chk_idle("t6_alloff");
    chk("t6_alloff_steal", StealPulse, 0);
    chk("t6_alloff_ready", EvReady, 1);

    // Reset asserted during LOOKUP
    do_ev(1, 8'd48, 7'd100);
    chk("t7_pre_gate", VoiceGate, 4'b0001);
    EvValid = 1'b1; EvNoteOn = 1'b1; EvPitch = 8'd52; EvVelocity = 7'd100;
    @(negedge clk);
    EvValid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_idle("t7_rst_now");
    chk("t7_rst_ready", EvReady, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("t7_lost_event");
    // Ages back to 0..3: four fills then the fifth steals voice 0
    do_ev(1, 8'd60, 7'd100);
    do_ev(1, 8'd61, 7'd100);
    do_ev(1, 8'd62, 7'd100);
    do_ev(1, 8'd63, 7'd100);
    do_ev(1, 8'd64, 7'd100);
    chk("t7_age_steal_pulse", StealPulse, 1);
    chk("t7_age_steal_offs", VoiceOffset, {5'd15, 5'd14, 5'd13, 5'd16});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
# midi_voice_allocator

Parametrised, polyphonic successor to the single-key MIDI pitch-to-offset converter. It accepts note-on/note-off events through a valid/ready handshake, maps each in-range pitch to a key offset relative to a configurable base note, and assigns the note to one of NUM_VOICES oscillator voices. Allocation uses least-recently-allocated voice stealing. The block sits between the MIDI parser and the oscillator bank, and drives per-voice offset and gate signals.

## Interface
- NUM_VOICES, default 4: voice count; power of two, minimum 2.
- BASE_NOTE, default 48: MIDI pitch that maps to offset 0 (C3).
- NUM_KEYS, default 24: playable range, BASE_NOTE to BASE_NOTE+NUM_KEYS-1; BASE_NOTE+NUM_KEYS ≤ 128.
- OFFSET_W, default 5: offset width; must satisfy 2^OFFSET_W > NUM_KEYS.

Ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- EvValid  in  1  an event is presented.
- EvReady  out  1  the block can accept an event.
- EvNoteOn  in  1  1 = note-on, 0 = note-off.
- EvPitch  in  8  MIDI note number; bit 7 is ignored.
- EvVelocity  in  7  note-on velocity; 0 is treated as note-off.
- AllOff  in  1  synchronous clear of all voices.
- VoiceGate  out  NUM_VOICES  1 = voice sounding.
- VoiceOffset  out  NUM_VOICES*OFFSET_W  voice i at bits [i*OFFSET_W +: OFFSET_W].
- VoiceVelocity  out  NUM_VOICES*7  latched velocity per voice.
- StealPulse  out  1  one-cycle pulse when a sounding voice is reassigned.
- RangePulse  out  1  one-cycle pulse when an event is dropped as out of range.

## Operation
- Idle offset code is NUM_KEYS. Any voice with gate 0 shows this code on VoiceOffset.
- Reset values:
  - EvReady = 1.
  - VoiceGate = 0.
  - All VoiceOffset = NUM_KEYS.
  - VoiceVelocity = 0.
  - StealPulse = 0, RangePulse = 0.
  - FSM state = IDLE.
  - Voice i age = i.
- FSM states: IDLE → LOOKUP → APPLY → IDLE.
  - IDLE: EvReady = 1. An event is accepted when EvValid && EvReady. On acceptance, latch the event fields and go to LOOKUP.
  - LOOKUP: EvReady = 0. Compute the offset as EvPitch[6:0] − BASE_NOTE, using 8-bit arithmetic truncated to OFFSET_W. Range check is BASE_NOTE ≤ pitch < BASE_NOTE+NUM_KEYS. Select the target voice and register its index, then go to APPLY.
  - APPLY: EvReady = 0. Update the target voice, pulse StealPulse or RangePulse if applicable, then go to IDLE.
- Target selection for note-on, in priority order:
  1. A gated voice already holding the same offset: retrigger it, update velocity, leave ages unchanged.
  2. The lowest-index ungated voice.
  3. The gated voice with the highest age; assert StealPulse.
- Note-on with EvVelocity 0 is handled exactly as a note-off.
- Note-off: clear the gate of the gated voice holding that offset and set its offset to NUM_KEYS. If no voice matches, do nothing (no pulse).
- Out-of-range event: no voice changes; assert RangePulse in APPLY.
- Age rule on allocation (cases 2 and 3 only):
  - The chosen voice's age becomes 0.
  - Every voice whose age was lower than the chosen voice's old age increments by 1.
  - The ages therefore always remain a permutation of 0..NUM_VOICES−1.
- AllOff: clears all gates and offsets, has priority over APPLY in the same cycle, and preserves ages. If AllOff arrives during LOOKUP, the pending event still completes in APPLY on the next cycle.
- Reset asserted mid-operation returns every register to its reset value immediately; the in-flight event is lost.

## Timing
- An event accepted at edge T is in LOOKUP during T..T+1 and in APPLY during T+1..T+2.
- Voice outputs and pulses update at edge T+2, giving a latency of 2 cycles.
- EvReady is low from T to T+2 and high again after edge T+2.
- Sustained throughput is one event per 3 cycles.
- EvPitch, EvNoteOn and EvVelocity must remain stable only in the acceptance cycle; they are latched at T.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- midi_pkg holds:
  - the state enum (IDLE, LOOKUP, APPLY);
  - a note-event struct (note_on, pitch, velocity);
  - the MIDI_PITCH_W = 8 and MIDI_VEL_W = 7 constants;
  - an idle_code(NUM_KEYS) function.
- One sub-module, voice_age_tracker:
  - NUM_VOICES age registers;
  - an allocation strobe plus index input;
  - an oldest-voice index output.

## Test plan
- Reset, then note-on at pitch 48 and pitch 71 (velocity 100) → voice 0 gets offset 0 and voice 1 gets offset 23, both gated. A third note-on at pitch 72 → RangePulse, no voice changes.
- With 4 voices, note-on at pitches 50, 52, 54, 56, then 58 → voice 0 (oldest) is reassigned to offset 10 and StealPulse fires once. A further note-on at 60 steals voice 1.
- Note-on at 60 velocity 90, then note-on at 60 velocity 20 → the same voice is retriggered with velocity 20, no new voice is used, no steal.
- Note-on at 55, then note-on at 55 velocity 0 → the gate clears and the offset returns to 24. A subsequent note-off at 57 → no change, no pulse.
- Back-to-back EvValid held high with 3 events → EvReady pattern is 1,0,0,1,0,0,1, and each event's result appears 2 cycles after its acceptance.
- AllOff asserted in the APPLY cycle of a note-on, and rst_n asserted during LOOKUP → all gates are 0 and all offsets are 24 in both cases. After reset, ages are 0..3 and EvReady = 1.
